// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding used by the alu and every ALU sequencer,
// plus the multiply sequencer state type.
package alu_pkg;

    localparam int ALU_CTRL_W = 3;

    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd4,
        ALU_ORR = 3'd5
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mul_state_t;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Request/response and ALU-borrow bus of the shift-add multiply sequencer.
// addend_i is present only when ALU_MUL_SEQ_MAC_EN is defined.
interface alu_mul_seq_if #(
    parameter int WIDTH = 4
);
    import alu_pkg::*;

    logic                  start_i;
    logic [WIDTH-1:0]      op_a_i;
    logic [WIDTH-1:0]      op_b_i;
`ifdef ALU_MUL_SEQ_MAC_EN
    logic [WIDTH-1:0]      addend_i;
`endif
    logic                  ready_o;
    logic                  done_o;
    logic [2*WIDTH-1:0]    product_o;
    logic [WIDTH-1:0]      alu_a_o;
    logic [WIDTH-1:0]      alu_b_o;
    logic [ALU_CTRL_W-1:0] alu_control_o;
    logic [WIDTH-1:0]      alu_result_i;
    logic                  alu_flag_c_i;

    // The sequencer side: consumes requests and ALU results, drives product and ALU operands.
    modport slave (
        input  start_i, op_a_i, op_b_i,
`ifdef ALU_MUL_SEQ_MAC_EN
        input  addend_i,
`endif
        input  alu_result_i, alu_flag_c_i,
        output ready_o, done_o, product_o,
        output alu_a_o, alu_b_o, alu_control_o
    );

    modport master (
        output start_i, op_a_i, op_b_i,
`ifdef ALU_MUL_SEQ_MAC_EN
        output addend_i,
`endif
        output alu_result_i, alu_flag_c_i,
        input  ready_o, done_o, product_o,
        input  alu_a_o, alu_b_o, alu_control_o
    );

endinterface

// File: rtl/alu.sv
// Shared combinational ALU of the execute stage: add, subtract, and, or with carry-out.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    input  logic [ALU_CTRL_W-1:0] alu_control,
    output logic [WIDTH-1:0]      result,
    output logic                  flag_c
);

    logic [WIDTH:0] sum;

    // Subtract is a + ~b + 1, so flag_c reads as "no borrow" for SUB.
    always_comb begin
        sum    = '0;
        result = '0;
        flag_c = 1'b0;
        case (alu_control)
            ALU_ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                result = sum[WIDTH-1:0];
                flag_c = sum[WIDTH];
            end
            ALU_SUB: begin
                sum    = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
                result = sum[WIDTH-1:0];
                flag_c = sum[WIDTH];
            end
            ALU_AND: result = a & b;
            ALU_ORR: result = a | b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier that borrows the external alu for one add per cycle.
// Define ALU_MUL_SEQ_MAC_EN to add addend_i and compute op_a*op_b + addend.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    alu_mul_seq_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    mul_state_t         state_q;
    mul_state_t         state_d;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   acc_hi_q;
    logic [WIDTH-1:0]   acc_lo_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] product_q;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   acc_hi_init;
    logic               accept;
    logic               last_iter;

    logic               ready;
    logic               done;
    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_b;
    logic [ALU_CTRL_W-1:0] alu_control;

`ifdef ALU_MUL_SEQ_MAC_EN
    assign acc_hi_init = bus.addend_i;
`else
    assign acc_hi_init = '0;
`endif

    // The ALU carry becomes the new top bit, so the full product never overflows.
    assign acc_next  = {bus.alu_flag_c_i, bus.alu_result_i, acc_lo_q[WIDTH-1:1]};
    assign last_iter = (cnt_q == CNT_W'(1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        ready       = 1'b0;
        done        = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        alu_control = ALU_ADD;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (bus.start_i) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                alu_a = acc_hi_q;
                alu_b = acc_lo_q[0] ? mcand_q : '0;
                if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // product_q is captured on the final iteration so it is valid together with done.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcand_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else if (accept) begin
            mcand_q  <= bus.op_a_i;
            acc_lo_q <= bus.op_b_i;
            acc_hi_q <= acc_hi_init;
            cnt_q    <= CNT_W'(WIDTH);
        end else if (state_q == BUSY) begin
            {acc_hi_q, acc_lo_q} <= acc_next;
            cnt_q                <= cnt_q - CNT_W'(1);
            if (last_iter) begin
                product_q <= acc_next;
            end
        end
    end

    assign bus.ready_o       = ready;
    assign bus.done_o        = done;
    assign bus.product_o     = product_q;
    assign bus.alu_a_o       = alu_a;
    assign bus.alu_b_o       = alu_b;
    assign bus.alu_control_o = alu_control;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq paired with the shared alu, at WIDTH 4 and WIDTH 8.
module tb_alu_mul_seq;
    import alu_pkg::*;

    typedef struct {
        logic [15:0] product;
        int          done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    logic prev_done = 1'b0;
    exp_t sb[$];

    alu_mul_seq_if #(.WIDTH(4)) bus ();
    alu_mul_seq_if #(.WIDTH(8)) bus8 ();

    alu #(.WIDTH(4)) u_alu (
        .a           (bus.alu_a_o),
        .b           (bus.alu_b_o),
        .alu_control (bus.alu_control_o),
        .result      (bus.alu_result_i),
        .flag_c      (bus.alu_flag_c_i)
    );

    alu_mul_seq #(.WIDTH(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    alu #(.WIDTH(8)) u_alu8 (
        .a           (bus8.alu_a_o),
        .b           (bus8.alu_b_o),
        .alu_control (bus8.alu_control_o),
        .result      (bus8.alu_result_i),
        .flag_c      (bus8.alu_flag_c_i)
    );

    alu_mul_seq #(.WIDTH(8)) dut8 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus8.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Drives a request and holds start until the DUT accepts; returns in the first BUSY cycle.
    task automatic apply_stimulus(input logic [3:0] a, input logic [3:0] b,
                                  input logic [7:0] product, input bit expect_done);
        int   n;
        exp_t e;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_a_i  = a;
        bus.op_b_i  = b;
        n = 0;
        while (!bus.ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            check_output("accept_timeout", 32'(n), 32'(0));
        end
        if (expect_done) begin
            e.product  = 16'(product);
            e.done_cyc = cyc + 4 + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.start_i = 1'b0;
        check_output("ready_drop", 32'(bus.ready_o), 32'(0));
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation in value and timing.
    always @(negedge clk) begin
        exp_t e;
        if (bus.done_o === 1'b1) begin
            if (sb.size() == 0) begin
                check_output("unexpected_done", 32'(1), 32'(0));
            end else begin
                e = sb.pop_front();
                check_output("product", 32'(bus.product_o), 32'(e.product));
                check_output("done_latency", 32'(cyc), 32'(e.done_cyc));
            end
            check_output("done_width", 32'(prev_done), 32'(0));
        end
        prev_done = bus.done_o;
    end

    initial begin
        logic [3:0] exp_alu_a [4];
        int n;
        int c0;
        exp_alu_a[0] = 4'd0;
        exp_alu_a[1] = 4'd7;
        exp_alu_a[2] = 4'd11;
        exp_alu_a[3] = 4'd13;

        bus.start_i  = 1'b0;
        bus.op_a_i   = '0;
        bus.op_b_i   = '0;
        bus8.start_i = 1'b0;
        bus8.op_a_i  = '0;
        bus8.op_b_i  = '0;
`ifdef ALU_MUL_SEQ_MAC_EN
        bus.addend_i  = '0;
        bus8.addend_i = '0;
`endif
        repeat (3) @(negedge clk);
        check_output("rst_ready",   32'(bus.ready_o),       32'(1));
        check_output("rst_done",    32'(bus.done_o),        32'(0));
        check_output("rst_product", 32'(bus.product_o),     32'(0));
        check_output("rst_alu_a",   32'(bus.alu_a_o),       32'(0));
        check_output("rst_alu_b",   32'(bus.alu_b_o),       32'(0));
        check_output("rst_alu_ctl", 32'(bus.alu_control_o), 32'(ALU_ADD));
        rst = 1'b0;

        $display("[TB] case 1: 2*5");
        apply_stimulus(4'd2, 4'd5, 8'd10, 1'b1);

        $display("[TB] case 2: 15*15 with ALU bus checks");
        apply_stimulus(4'd15, 4'd15, 8'd225, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            check_output("busy_alu_b",   32'(bus.alu_b_o),       32'(15));
            check_output("busy_alu_ctl", 32'(bus.alu_control_o), 32'(ALU_ADD));
            check_output("busy_alu_a",   32'(bus.alu_a_o),       32'(exp_alu_a[i]));
        end

        $display("[TB] case 3: zero operands");
        apply_stimulus(4'd0, 4'd9, 8'd0, 1'b1);
        apply_stimulus(4'd9, 4'd0, 8'd0, 1'b1);

        $display("[TB] case 4: start during BUSY is ignored");
        apply_stimulus(4'd3, 4'd7, 8'd21, 1'b1);
        bus.start_i = 1'b1;
        bus.op_a_i  = 4'd1;
        bus.op_b_i  = 4'd5;
        @(negedge clk);
        bus.start_i = 1'b0;
        apply_stimulus(4'd4, 4'd4, 8'd16, 1'b1);
        check_output("product_held", 32'(bus.product_o), 32'(21));

        $display("[TB] case 5: reset mid-operation");
        apply_stimulus(4'd13, 4'd11, 8'd143, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("midrst_ready",   32'(bus.ready_o),   32'(1));
        check_output("midrst_product", 32'(bus.product_o), 32'(0));
        repeat (10) @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_a_i  = 4'd2;
        bus.op_b_i  = 4'd3;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.start_i = 1'b0;
        check_output("rst_over_start", 32'(bus.ready_o), 32'(1));
        apply_stimulus(4'd13, 4'd11, 8'd143, 1'b1);

`ifdef ALU_MUL_SEQ_MAC_EN
        $display("[TB] case 6: multiply-accumulate");
        bus.addend_i = 4'd15;
        apply_stimulus(4'd15, 4'd15, 8'd240, 1'b1);
        @(negedge clk);
        bus.addend_i = 4'd0;
`endif

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_output("scoreboard_drained", 32'(sb.size()), 32'(0));

        $display("[TB] case 6: WIDTH=8 255*255");
        @(negedge clk);
        bus8.start_i = 1'b1;
        bus8.op_a_i  = 8'd255;
        bus8.op_b_i  = 8'd255;
        c0 = cyc;
        @(negedge clk);
        bus8.start_i = 1'b0;
        n = 0;
        while (bus8.done_o !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check_output("w8_latency", 32'(cyc - c0), 32'(9));
        check_output("w8_product", 32'(bus8.product_o), 32'(65025));

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle unsigned shift-add multiplier sequencer that borrows the shared combinational alu through its external bus/control ports.
- Accepts two WIDTH-bit operands over a start/ready handshake and produces a 2*WIDTH-bit product after a fixed latency.
- Drives the ALU operand buses and opcode, and consumes the ALU result and carry flag.
- Sits beside the alu in the execute stage and gives the core a MUL path without a dedicated multiplier array.

Parameters:
WIDTH, 4, operand width; must match the attached alu's WIDTH; legal range 2..32

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  synchronous active-high reset
start_i  input  1  request to start a multiply; accepted only when ready_o=1
op_a_i  input  WIDTH  multiplicand, sampled on accept
op_b_i  input  WIDTH  multiplier, sampled on accept
ready_o  output  1  high only in IDLE
done_o  output  1  single-cycle pulse when product_o becomes valid
product_o  output  2*WIDTH  result; held until the next accept
alu_a_o  output  WIDTH  ALU bus A (running upper accumulator)
alu_b_o  output  WIDTH  ALU bus B (multiplicand or zero)
alu_control_o  output  3  ALU opcode
alu_result_i  input  WIDTH  ALU result bus
alu_flag_c_i  input  1  ALU carry-out flag

Behaviour:
- One clock; reset is synchronous and active-high; clock and reset ports are clk_i / rst_i.
- Reset values: state=IDLE, ready_o=1, done_o=0, product_o=0, alu_a_o=0, alu_b_o=0, alu_control_o=ALU_ADD.
- Internal registers: mcand (WIDTH), acc_hi (WIDTH), acc_lo (WIDTH), cnt ($clog2(WIDTH+1) bits).
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - On start_i=1: load mcand=op_a_i, acc_lo=op_b_i, acc_hi=0, cnt=WIDTH; go to BUSY.
  - product_o is unchanged on accept; it keeps the previous value until DONE.
- BUSY, one iteration per cycle:
  - alu_control_o=ALU_ADD, alu_a_o=acc_hi, alu_b_o = acc_lo[0] ? mcand : 0.
  - On the clock edge, {acc_hi, acc_lo} <= {alu_flag_c_i, alu_result_i, acc_lo[WIDTH-1:1]}; cnt <= cnt-1.
  - When cnt==1, go to DONE.
- DONE:
  - product_o <= {acc_hi, acc_lo} is registered on entry; done_o=1 for exactly this one cycle.
  - Next state is always IDLE. ready_o=0, so start_i is ignored.
- Latency: accept at edge T; done_o high in cycle T+WIDTH+1; the next accept is possible at edge T+WIDTH+2.
- Throughput: one multiply per WIDTH+2 cycles.
- Outside BUSY, the ALU outputs return to their reset values.
- start_i in BUSY or DONE is ignored with no queuing; the requester must hold start_i until it sees ready_o.
- Operands are sampled only at accept; changes on op_a_i/op_b_i during BUSY have no effect.
- Zero operand: full latency still applies; the result is 0.
- Maximum operands: (2^WIDTH-1)^2 always fits in 2*WIDTH bits; carry is captured, no overflow.
- Reset mid-operation: back to IDLE next edge; product_o=0, done_o stays 0, no late done pulse.
- Reset has priority over start_i in the same cycle.

Optional Feature:
- Macro: ALU_MUL_SEQ_MAC_EN.
- Defined:
  - Adds port addend_i input WIDTH.
  - On accept, acc_hi is loaded with addend_i instead of 0, so product_o = op_a_i*op_b_i + addend_i.
  - The maximum (2^WIDTH-1)^2 + 2^WIDTH-1 < 2^(2*WIDTH), so there is never overflow.
  - Timing and handshake are unchanged.
- Undefined:
  - Port is absent and acc_hi is loaded with 0.

Decomposition:
- Package alu_pkg holds:
  - alu_op_t (3-bit) with ALU_ADD=3'd0, ALU_SUB=3'd1, ALU_AND=3'd4, ALU_ORR=3'd5. The alu and every future ALU sequencer share this package.
  - mul_state_t enum {IDLE, BUSY, DONE}.
- No sub-module: the shift register and counter are small and stay inline.
- The alu instance lives in the parent, not inside this block, so the parent can later arbitrate the ALU between this sequencer and the main decode path.

Test Plan:
- Bench instantiates alu #(4) connected to alu_mul_seq #(4).
- Case 1: start with op_a=2, op_b=5 → ready_o drops the next cycle; done_o pulses exactly 5 cycles after accept; product_o=8'd10.
- Case 2: op_a=15, op_b=15 → product_o=8'd225; check alu_b_o=15 on every BUSY cycle and alu_control_o=ALU_ADD.
- Case 3: op_a=0, op_b=9, then op_a=9, op_b=0 → both give product_o=0 with full 5-cycle latency; done_o is one cycle wide.
- Case 4: op_a=3, op_b=7, then pulse start_i with op_a=1 during BUSY → second request ignored; product_o=21.
  - Then hold start_i with op_a=4, op_b=4 → accepted on the IDLE cycle; product_o=16.
- Case 5: assert rst_i on the 2nd BUSY cycle of 13*11 → ready_o=1 and product_o=0 the next cycle; no done_o for 10 cycles.
  - A fresh 13*11 then gives 143.
- Case 6: with ALU_MUL_SEQ_MAC_EN, op_a=15, op_b=15, addend=15 → product_o=240.
  - With WIDTH=8 (no macro), 255*255 → 65025 in 9 cycles.
